// File: rtl/freq_meter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | freq_meter_pkg : shared FSM state type and synchroniser depth     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int SYNC_STAGES = 2;

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sync_edge_det : multi-flop synchroniser plus rising-edge pulse    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sync_edge_det
  import freq_meter_pkg::*;
(
  input  logic clk_in,
  input  logic nreset,
  input  logic async_in,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_in or negedge nreset) begin
    if (!nreset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/freq_meter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | freq_meter : counts clk_meas rising edges over a GATE_CYCLES      |
// | window. FREQ_METER_CONT_EN selects continuous re-measurement.     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 50000,
  parameter int CNT_W       = 16
) (
  input  logic             clk_in,
  input  logic             nreset,
  input  logic             clk_meas,
  input  logic             start,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_count,
  output logic             meas_ovf,
  output logic             busy
);

  localparam int               GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t            state;
  state_t            state_nxt;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic [CNT_W-1:0]  edge_cnt_nxt;
  logic              sat;
  logic              sat_nxt;
  logic              edge_pulse;
  logic              gate_done;

  sync_edge_det u_sync_edge_det (
    .clk_in     (clk_in),
    .nreset     (nreset),
    .async_in   (clk_meas),
    .edge_pulse (edge_pulse)
  );

  assign gate_done = (state == GATE) && (gate_cnt == GATE_LAST);

  // Saturating edge count; the current cycle's pulse is folded in so the final gate cycle counts.
  always_comb begin
    edge_cnt_nxt = edge_cnt;
    sat_nxt      = sat;
    if (edge_pulse) begin
      if (edge_cnt == CNT_MAX) begin
        sat_nxt = 1'b1;
      end else begin
        edge_cnt_nxt = edge_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = GATE;
      GATE: if (gate_done) state_nxt = HOLD;
      HOLD: begin
        if (meas_ready) begin
`ifdef FREQ_METER_CONT_EN
          state_nxt = GATE;
`else
          state_nxt = IDLE;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counters are held clear outside GATE, so every window starts from zero.
  always_ff @(posedge clk_in or negedge nreset) begin
    if (!nreset) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      sat        <= 1'b0;
      meas_count <= '0;
      meas_ovf   <= 1'b0;
    end else if (state != GATE) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat      <= 1'b0;
    end else begin
      gate_cnt <= gate_cnt + GATE_W'(1);
      edge_cnt <= edge_cnt_nxt;
      sat      <= sat_nxt;
      if (gate_done) begin
        meas_count <= edge_cnt_nxt;
        meas_ovf   <= sat_nxt;
      end
    end
  end

  assign meas_valid = (state == HOLD);
  assign busy       = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_freq_meter : scoreboard bench for freq_meter (two configs)     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_freq_meter;

  typedef struct {
    int   lo;
    int   hi;
    logic ovf;
  } exp_t;

  logic        clk_in     = 1'b0;
  logic        nreset     = 1'b0;
  logic        clk_meas_a = 1'b0;
  logic        clk_meas_b = 1'b0;
  logic        start_a    = 1'b0;
  logic        start_b    = 1'b0;
  logic        ready_a    = 1'b1;
  logic        ready_b    = 1'b1;
  logic        valid_a, ovf_a, busy_a;
  logic        valid_b, ovf_b, busy_b;
  logic [15:0] count_a;
  logic [3:0]  count_b;

  int   checks = 0;
  int   errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk_in = ~clk_in;
  initial begin #3; forever #50 clk_meas_a = ~clk_meas_a; end
  initial begin #7; forever #40 clk_meas_b = ~clk_meas_b; end

  freq_meter #(.GATE_CYCLES(100), .CNT_W(16)) dut_a (
    .clk_in(clk_in), .nreset(nreset), .clk_meas(clk_meas_a), .start(start_a),
    .meas_ready(ready_a), .meas_valid(valid_a), .meas_count(count_a),
    .meas_ovf(ovf_a), .busy(busy_a)
  );

  freq_meter #(.GATE_CYCLES(200), .CNT_W(4)) dut_b (
    .clk_in(clk_in), .nreset(nreset), .clk_meas(clk_meas_b), .start(start_b),
    .meas_ready(ready_b), .meas_valid(valid_b), .meas_count(count_b),
    .meas_ovf(ovf_b), .busy(busy_b)
  );

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // Scoreboard monitors: compare on the first cycle each result is presented.
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;
  always @(negedge clk_in) begin : mon_a
    exp_t ea;
    if (valid_a && !prev_a) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL result_a: unexpected result count %0d ovf %0b", count_a, ovf_a);
      end else begin
        ea = q_a.pop_front();
        if (int'(count_a) < ea.lo || int'(count_a) > ea.hi || ovf_a !== ea.ovf) begin
          errors++;
          $display("FAIL result_a: actual count %0d ovf %0b required count %0d..%0d ovf %0b",
                   count_a, ovf_a, ea.lo, ea.hi, ea.ovf);
        end
      end
    end
    prev_a <= valid_a;
  end

  always @(negedge clk_in) begin : mon_b
    exp_t eb;
    if (valid_b && !prev_b) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL result_b: unexpected result count %0d ovf %0b", count_b, ovf_b);
      end else begin
        eb = q_b.pop_front();
        if (int'(count_b) < eb.lo || int'(count_b) > eb.hi || ovf_b !== eb.ovf) begin
          errors++;
          $display("FAIL result_b: actual count %0d ovf %0b required count %0d..%0d ovf %0b",
                   count_b, ovf_b, eb.lo, eb.hi, eb.ovf);
        end
      end
    end
    prev_b <= valid_b;
  end

  // Pulse start on A, then count cycles until the result appears; optional re-start mid-window.
  task automatic meas_a(input int restart_at, output int win);
    start_a = 1'b1;
    @(posedge clk_in); #1;
    start_a = 1'b0;
    check("busy_after_start_a", busy_a, 1);
    win = 0;
    while (!valid_a && win < 1000) begin
      @(posedge clk_in); #1;
      win++;
      start_a = (win == restart_at);
    end
    start_a = 1'b0;
    check("valid_seen_a", valid_a, 1);
  endtask

  // Continuous mode never returns to IDLE on its own, so stop it with a reset.
  task automatic stop_meters();
`ifdef FREQ_METER_CONT_EN
    @(posedge clk_in); #1;
    nreset = 1'b0;
    #2 nreset = 1'b1;
    @(posedge clk_in); #1;
`endif
  endtask

  int win;
  logic [15:0] cap_count;
  logic        cap_ovf;
  logic        stable;

  initial begin
    repeat (3) @(posedge clk_in);
    #1;
    check("reset_valid_a", valid_a, 0);
    check("reset_count_a", count_a, 0);
    check("reset_ovf_a",   ovf_a,   0);
    check("reset_busy_a",  busy_a,  0);
    check("reset_valid_b", valid_b, 0);
    nreset = 1'b1;

    // Basic measurement, ready already high.
    q_a.push_back('{9, 11, 1'b0});
    meas_a(0, win);
    check("window_a", win, 100);
    @(posedge clk_in); #1;
    check("valid_drop_a", valid_a, 0);
    stop_meters();

    // Start re-pulsed during GATE must not restart the window.
    q_a.push_back('{9, 11, 1'b0});
    meas_a(30, win);
    check("window_restart_a", win, 100);
    @(posedge clk_in); #1;
    stop_meters();

    // Back-pressure in HOLD.
    ready_a = 1'b0;
    q_a.push_back('{9, 11, 1'b0});
    meas_a(0, win);
    cap_count = count_a;
    cap_ovf   = ovf_a;
    stable    = 1'b1;
    repeat (50) begin
      @(posedge clk_in); #1;
      if (!valid_a || count_a != cap_count || ovf_a != cap_ovf) stable = 1'b0;
    end
    check("hold_stable_a", stable, 1);
    ready_a = 1'b1;
    @(posedge clk_in); #1;
    check("hold_release_valid_a", valid_a, 0);
`ifdef FREQ_METER_CONT_EN
    check("hold_release_busy_a", busy_a, 1);
`else
    check("hold_release_busy_a", busy_a, 0);
`endif
    stop_meters();

    // Abort mid-GATE with asynchronous reset.
    start_a = 1'b1;
    @(posedge clk_in); #1;
    start_a = 1'b0;
    repeat (40) @(posedge clk_in);
    #1 nreset = 1'b0;
    #1;
    check("abort_valid_a", valid_a, 0);
    check("abort_count_a", count_a, 0);
    check("abort_ovf_a",   ovf_a,   0);
    check("abort_busy_a",  busy_a,  0);
    #2 nreset = 1'b1;
    @(posedge clk_in); #1;
    q_a.push_back('{9, 11, 1'b0});
    meas_a(0, win);
    check("window_after_abort_a", win, 100);
    @(posedge clk_in); #1;
    stop_meters();

    // Saturation on the narrow instance: 25 edges into a 4-bit counter.
    q_b.push_back('{15, 15, 1'b1});
    start_b = 1'b1;
    @(posedge clk_in); #1;
    start_b = 1'b0;
    win = 0;
    while (!valid_b && win < 2000) begin
      @(posedge clk_in); #1;
      win++;
    end
    check("window_b", win, 200);
    @(posedge clk_in); #1;
    check("valid_drop_b", valid_b, 0);
    stop_meters();

`ifdef FREQ_METER_CONT_EN
    // Continuous mode: one start, results every GATE_CYCLES+1 cycles.
    repeat (3) q_a.push_back('{9, 11, 1'b0});
    start_a = 1'b1;
    @(posedge clk_in); #1;
    start_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      win = 0;
      do begin
        @(posedge clk_in); #1;
        win++;
      end while (!valid_a && win < 1000);
      check("cont_period_a", win, (k == 0) ? 100 : 101);
    end
    @(posedge clk_in); #1;
    stop_meters();
`endif

    repeat (5) @(posedge clk_in);
    #1;
    check("pending_a", q_a.size(), 0);
    check("pending_b", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
